// File: rtl/coef_pkg.sv
// coef_pkg: shared widths, loader state encoding and default coefficient count for coef_memory.
package coef_pkg;
    localparam int COEF_W         = 18;
    localparam int ADDR_W         = 7;
    localparam int BYTES_PER_WORD = 3;
    localparam int NTAPS          = 65;
    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;
endpackage

// File: rtl/coef_ram.sv
// coef_ram: COEF_W x DEPTH single-clock RAM, synchronous write, registered read (read-before-write).
// Ports: clock, reset (async, clears read register only), we/waddr/wdata write port, raddr/rdata read port.
module coef_ram
    import coef_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COEF_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COEF_W-1:0] rdata
);
    // Power-up contents are zero; reset deliberately leaves storage untouched.
    logic [COEF_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock)
        if (we)
            mem[waddr] <= wdata;

    // Non-blocking update of mem means a same-address read returns the old word.
    always_ff @(posedge clock or posedge reset)
        if (reset)
            rdata <= '0;
        else
            rdata <= mem[raddr];
endmodule

// File: rtl/coef_memory.sv
// coef_memory: FIR coefficient store with 1-cycle registered read port and byte-serial valid/ready loader.
// Ports: clock, reset (async high); coefaddress -> coefdata (1-cycle latency); coef_valid after a full load;
//        load_start/load_byte/load_valid/load_ready byte port; load_busy, load_done pulse, word_count, checksum.
// Macro COEF_CHECKSUM_EN: when defined, checksum accumulates written words mod 2^COEF_W; otherwise it is 0.
module coef_memory
    import coef_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int NWORDS = NTAPS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] coefaddress,
    output logic [COEF_W-1:0] coefdata,
    output logic              coef_valid,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W-1:0] word_count,
    output logic [COEF_W-1:0] checksum
);
    state_t            state, state_n;
    logic [1:0]        hi, hi_n;
    logic [7:0]        mid, mid_n;
    logic [ADDR_W-1:0] count_n;
    logic              valid_n, done_n, accept, we, last;
    logic [COEF_W-1:0] word;

    assign load_ready = state != IDLE;
    assign load_busy  = load_ready;
    assign accept     = load_valid && load_ready;
    // The final byte is consumed straight into the write, so no third holding register is needed.
    assign word       = {hi, mid, load_byte};
    assign last       = word_count == ADDR_W'(NWORDS - 1);

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state      <= IDLE;
            hi         <= '0;
            mid        <= '0;
            word_count <= '0;
            coef_valid <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_n;
            hi         <= hi_n;
            mid        <= mid_n;
            word_count <= count_n;
            coef_valid <= valid_n;
            load_done  <= done_n;
        end

    // load_start wins over a byte in the same cycle, both to start and to abort.
    always_comb begin
        state_n = state;
        hi_n    = hi;
        mid_n   = mid;
        count_n = word_count;
        valid_n = coef_valid;
        done_n  = 1'b0;
        we      = 1'b0;
        if (load_start) begin
            state_n = B0;
            count_n = '0;
            valid_n = 1'b0;
        end else if (accept) begin
            case (state)
                B0: begin
                    hi_n    = load_byte[1:0];
                    state_n = B1;
                end
                B1: begin
                    mid_n   = load_byte;
                    state_n = B2;
                end
                B2: begin
                    we      = 1'b1;
                    count_n = word_count + 1'b1;
                    state_n = last ? IDLE : B0;
                    done_n  = last;
                    valid_n = last;
                end
                default: ;
            endcase
        end
    end

`ifdef COEF_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset)
        if (reset)
            checksum <= '0;
        else if (load_start)
            checksum <= '0;
        else if (we)
            checksum <= checksum + word;
`else
    assign checksum = '0;
`endif

    coef_ram #(.DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (word_count),
        .wdata (word),
        .raddr (coefaddress),
        .rdata (coefdata)
    );
endmodule

// File: tb/tb_coef_memory.sv
// tb_coef_memory: self-checking bench for coef_memory with a byte-queue reference model and directed loads.
module tb_coef_memory;
    localparam int NW = 65;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  coefaddress = '0;
    logic [17:0] coefdata;
    logic        coef_valid;
    logic        load_start = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic [6:0]  word_count;
    logic [17:0] checksum;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen = 0;

    coef_memory dut (
        .clock       (clock),
        .reset       (reset),
        .coefaddress (coefaddress),
        .coefdata    (coefdata),
        .coef_valid  (coef_valid),
        .load_start  (load_start),
        .load_byte   (load_byte),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .word_count  (word_count),
        .checksum    (checksum)
    );

    always #5 clock = ~clock;

    // Reference model: storage array plus a list of bytes received for the word in progress.
    logic [17:0] m_mem [128];
    logic [17:0] m_data  = '0;
    logic [17:0] m_sum   = '0;
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_done  = 1'b0;
    int          m_count = 0;
    logic [7:0]  bq [$];

    initial begin
        logic [17:0] w;
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_data = '0; m_sum = '0; m_busy = 0; m_valid = 0; m_done = 0; m_count = 0;
                bq.delete();
            end else begin
                m_data = m_mem[coefaddress];
                m_done = 0;
                if (load_start) begin
                    m_busy = 1; m_count = 0; m_valid = 0; m_sum = '0;
                    bq.delete();
                end else if (m_busy && load_valid) begin
                    bq.push_back(load_byte);
                    if (bq.size() == 3) begin
                        w = {bq[0][1:0], bq[1], bq[2]};
                        bq.delete();
                        m_mem[m_count] = w;
                        m_sum = m_sum + w;
                        m_count++;
                        if (m_count == NW) begin
                            m_busy = 0; m_done = 1; m_valid = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_sum(input logic [17:0] s);
`ifdef COEF_CHECKSUM_EN
        return s;
`else
        return (s & 18'h0);
`endif
    endfunction

    // Cycle-by-cycle comparison against the model, on the inactive edge.
    initial forever begin
        @(negedge clock);
        if (load_done) done_seen++;
        chk("coefdata",   coefdata,            m_data);
        chk("coef_valid", 18'(coef_valid),     18'(m_valid));
        chk("load_ready", 18'(load_ready),     18'(m_busy));
        chk("load_busy",  18'(load_busy),      18'(m_busy));
        chk("load_done",  18'(load_done),      18'(m_done));
        chk("word_count", 18'(word_count),     18'(m_count));
        chk("checksum",   checksum,            exp_sum(m_sum));
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse(input logic with_byte);
        load_start = 1; load_valid = with_byte; load_byte = 8'hFF;
        tick;
        load_start = 0; load_valid = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        load_valid = 1; load_byte = b;
        tick;
        load_valid = 0;
        repeat (gap) tick;
    endtask

    task automatic send_word(input logic [17:0] w, input int gap);
        send_byte({6'b0, w[17:16]}, gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    function automatic logic [17:0] pat_a(input int k);
        return {2'b01, 8'(k), 8'hA5};
    endfunction

    task automatic read_chk(input string name, input logic [6:0] a, input logic [17:0] exp);
        coefaddress = a;
        tick;
        chk(name, coefdata, exp);
    endtask

    initial begin
        int d0;
        repeat (3) tick;
        reset = 0;
        tick;
        read_chk("rst_rd0", 7'd0, 18'h0);
        read_chk("rst_rd64", 7'd64, 18'h0);
        chk("rst_valid", 18'(coef_valid), 18'h0);
        chk("rst_ready", 18'(load_ready), 18'h0);

        // Back-to-back load of pattern A
        start_pulse(0);
        for (int k = 0; k < NW; k++) send_word(pat_a(k), 0);
        tick;
        chk("a_count", 18'(word_count), 18'd65);
        chk("a_valid", 18'(coef_valid), 18'h1);
        chk("a_done_once", 18'(done_seen), 18'd1);
        read_chk("a_rd3", 7'd3, 18'h103A5);

        // Bytes offered while idle must be ignored
        send_byte(8'h77, 0);
        send_byte(8'h77, 0);
        chk("idle_count", 18'(word_count), 18'd65);
        chk("idle_ready", 18'(load_ready), 18'h0);

        // Gapped load of pattern A
        start_pulse(0);
        for (int k = 0; k < NW; k++) send_word(pat_a(k), 5);
        tick;
        chk("gap_done", 18'(done_seen), 18'd2);
        for (int k = 0; k < NW; k++) read_chk("gap_img", 7'(k), pat_a(k));

        // Aborted partial load, then a full load of all ones with a same-address read at word 5
        d0 = done_seen;
        start_pulse(0);
        for (int k = 0; k < 10; k++) send_word({2'b10, 8'(k), 8'h5A}, 0);
        send_byte(8'h02, 0);
        start_pulse(1);
        chk("abort_count", 18'(word_count), 18'd0);
        for (int k = 0; k < NW; k++) begin
            send_byte(8'h03, 0);
            send_byte(8'hFF, 0);
            if (k == 5) coefaddress = 7'd5;
            send_byte(8'hFF, 0);
            if (k == 5) chk("rbw_old", coefdata, 18'h2055A);
            if (k == 6) chk("rbw_new", coefdata, 18'h3FFFF);
        end
        tick;
        chk("abort_done_once", 18'(done_seen - d0), 18'd1);
        chk("ones_sum", checksum, exp_sum(18'h3FFBF));
        for (int k = 0; k < NW; k++) read_chk("ones_img", 7'(k), 18'h3FFFF);

        // Checksum wrap: 65 x 0x01000 mod 2^18
        start_pulse(0);
        for (int k = 0; k < NW; k++) send_word(18'h01000, 0);
        tick;
        chk("sum_1000", checksum, exp_sum(18'h01000));

        // Reset mid-load: loader returns to idle, storage retained
        start_pulse(0);
        send_word(18'h2AAAA, 0);
        send_byte(8'h01, 0);
        #2 reset = 1;
        tick;
        chk("mid_rst_valid", 18'(coef_valid), 18'h0);
        chk("mid_rst_busy", 18'(load_busy), 18'h0);
        chk("mid_rst_count", 18'(word_count), 18'h0);
        tick;
        reset = 0;
        tick;
        read_chk("mid_rst_keep", 7'd0, 18'h2AAAA);
        read_chk("mid_rst_keep1", 7'd1, 18'h01000);
        repeat (2) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
